// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC trace capture block.
package tdc_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam logic [SAMPLE_W-1:0] MARK_DONE_DEF = 8'hFF;

    typedef enum logic [2:0] {
        CAP_IDLE    = 3'd0,
        CAP_ARMED   = 3'd1,
        CAP_CAPTURE = 3'd2,
        CAP_FULL    = 3'd3,
        CAP_DUMP    = 3'd4
    } cap_state_e;

endpackage

// File: rtl/tdc_trace_capture_if.sv
// Byte-stream dump handshake from the trace recorder to the UART TX path.
interface tdc_trace_capture_if;
    import tdc_pkg::*;

    logic [SAMPLE_W-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);

endinterface

// File: rtl/tdc_trace_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module tdc_trace_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds its value while re is low; the dump pipeline relies on that.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tdc_trace_capture.sv
// Multi-channel sensor trace recorder: circular pre-trigger capture, frozen DEPTH-sample window
// with AES-done marker, then a byte-serial valid/ready dump of the window.
module tdc_trace_capture
    import tdc_pkg::*;
#(
    parameter int unsigned         NUM_CH    = 2,
    parameter int unsigned         DEPTH     = 512,
    parameter int unsigned         PRETRIG   = 16,
    parameter logic [SAMPLE_W-1:0] MARK_DONE = MARK_DONE_DEF,
    parameter bit                  MARK_EN   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_i,
    input  logic                       sample_vld_i,
    input  logic                       arm_i,
    input  logic                       trig_i,
    input  logic                       done_i,
    input  logic                       clear_i,
    input  logic                       dump_i,
    tdc_trace_capture_if.master        tx,
    output logic                       busy_o,
    output logic                       full_o,
    output logic                       pre_short_o
);

    localparam int unsigned AddrW    = $clog2(DEPTH);
    localparam int unsigned CntW     = AddrW + 1;
    localparam int unsigned RowW     = NUM_CH * SAMPLE_W;
    localparam int unsigned NumBytes = NUM_CH * DEPTH;
    localparam int unsigned ByteCntW = $clog2(NumBytes) + 1;

    localparam logic [CntW-1:0]     PreMax   = CntW'(PRETRIG);
    localparam logic [CntW-1:0]     DepthCnt = CntW'(DEPTH);
    localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(NumBytes - 1);
    localparam logic [1:0]          LastCh   = 2'(NUM_CH - 1);

    cap_state_e          state_q;
    logic [AddrW-1:0]    wr_ptr_q;
    logic [AddrW-1:0]    start_ptr_q;
    logic [CntW-1:0]     pre_cnt_q;
    logic [CntW-1:0]     post_cnt_q;
    logic [CntW-1:0]     zfill_q;
    logic                pre_short_q;

    logic [CntW-1:0]     iss_idx_q;
    logic                s1_vld_q;
    logic                s1_zero_q;
    logic [1:0]          ch_q;
    logic [ByteCntW-1:0] out_cnt_q;
    logic [SAMPLE_W-1:0] tx_data_q;
    logic                tx_valid_q;
    logic                tx_last_q;

    logic                ram_we;
    logic [RowW-1:0]     ram_wdata;
    logic                ram_re;
    logic [AddrW-1:0]    ram_raddr;
    logic [RowW-1:0]     ram_rdata;

    logic                in_armed;
    logic                in_capture;
    logic                mark;
    logic [CntW-1:0]     post_first;
    logic [CntW-1:0]     post_next;
    logic [CntW-1:0]     post_goal;
    logic                out_free;
    logic                load_out;
    logic                row_done;
    logic [SAMPLE_W-1:0] byte_sel;
    logic [SAMPLE_W-1:0] out_byte;

    always_comb begin
        in_armed   = (state_q == CAP_ARMED);
        in_capture = (state_q == CAP_CAPTURE);
        mark       = MARK_EN && done_i && (in_capture || (in_armed && trig_i));
        ram_we     = !clear_i && sample_vld_i && (in_armed || in_capture);
        ram_wdata  = mark ? {NUM_CH{MARK_DONE}} : sample_i;
        post_first = CntW'(sample_vld_i);
        post_next  = post_cnt_q + CntW'(sample_vld_i);
        // Pre-trigger samples plus post-trigger samples always make a DEPTH-long window.
        post_goal  = DepthCnt - pre_cnt_q;
    end

    // Dump pipeline: issue a row read, hold it in the RAM output register, peel off one byte per
    // accepted output slot, and only re-issue once the last byte of the row has been taken.
    always_comb begin
        out_free  = !tx_valid_q || tx.tx_ready;
        load_out  = s1_vld_q && out_free;
        row_done  = load_out && (ch_q == LastCh);
        ram_re    = (state_q == CAP_DUMP) && (iss_idx_q < DepthCnt) && (!s1_vld_q || row_done);
        // Unrecorded pre-trigger slots come first, so RAM data is offset by the zero-fill count.
        ram_raddr = start_ptr_q - AddrW'(zfill_q) + AddrW'(iss_idx_q);
        byte_sel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 2'(c)) begin
                byte_sel = ram_rdata[c*SAMPLE_W +: SAMPLE_W];
            end
        end
        out_byte = s1_zero_q ? '0 : byte_sel;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= CAP_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            zfill_q     <= '0;
            pre_short_q <= 1'b0;
            iss_idx_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            ch_q        <= '0;
            out_cnt_q   <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
        end else if (clear_i) begin
            state_q    <= CAP_IDLE;
            s1_vld_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                CAP_IDLE: begin
                    if (arm_i) begin
                        state_q     <= CAP_ARMED;
                        wr_ptr_q    <= '0;
                        pre_cnt_q   <= '0;
                        pre_short_q <= 1'b0;
                    end
                end
                CAP_ARMED: begin
                    if (trig_i) begin
                        start_ptr_q <= wr_ptr_q - AddrW'(pre_cnt_q);
                        pre_short_q <= (pre_cnt_q < PreMax);
                        zfill_q     <= PreMax - pre_cnt_q;
                        post_cnt_q  <= post_first;
                        state_q     <= (post_first == post_goal) ? CAP_FULL : CAP_CAPTURE;
                        if (sample_vld_i) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end else if (sample_vld_i) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (pre_cnt_q < PreMax) begin
                            pre_cnt_q <= pre_cnt_q + 1'b1;
                        end
                    end
                end
                CAP_CAPTURE: begin
                    if (sample_vld_i) begin
                        wr_ptr_q   <= wr_ptr_q + 1'b1;
                        post_cnt_q <= post_next;
                        if (post_next == post_goal) begin
                            state_q <= CAP_FULL;
                        end
                    end
                end
                CAP_FULL: begin
                    if (dump_i) begin
                        state_q   <= CAP_DUMP;
                        iss_idx_q <= '0;
                        out_cnt_q <= '0;
                        ch_q      <= '0;
                        s1_vld_q  <= 1'b0;
                    end
                end
                CAP_DUMP: begin
                    if (ram_re) begin
                        iss_idx_q <= iss_idx_q + 1'b1;
                        s1_zero_q <= (iss_idx_q < zfill_q);
                        s1_vld_q  <= 1'b1;
                    end else if (row_done) begin
                        s1_vld_q <= 1'b0;
                    end
                    if (load_out) begin
                        tx_data_q  <= out_byte;
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= (out_cnt_q == LastByte);
                        out_cnt_q  <= out_cnt_q + 1'b1;
                        ch_q       <= row_done ? 2'd0 : ch_q + 2'd1;
                    end else if (tx.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                    end
                    if (tx_valid_q && tx.tx_ready && tx_last_q) begin
                        state_q    <= CAP_IDLE;
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                    end
                end
                default: state_q <= CAP_IDLE;
            endcase
        end
    end

    tdc_trace_ram #(
        .WIDTH (RowW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_last  = tx_last_q;
    assign busy_o      = (state_q != CAP_IDLE);
    assign full_o      = (state_q == CAP_FULL);
    assign pre_short_o = pre_short_q;

endmodule

// File: tb/tb_tdc_trace_capture.sv
// Randomised bench for tdc_trace_capture: two instances (marker on/off) share stimulus and are
// compared against a window-level reference model of what the dump must contain.
module tb_tdc_trace_capture;
    import tdc_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned DEP = 16;
    localparam int unsigned PRE = 4;
    localparam int unsigned NB  = NCH * DEP;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [NCH*8-1:0] sample_i;
    logic           sample_vld_i, arm_i, trig_i, done_i, clear_i, dump_i, tx_ready;
    logic           busy_m, full_m, short_m, busy_r, full_r, short_r;

    tdc_trace_capture_if if_m ();
    tdc_trace_capture_if if_r ();
    assign if_m.tx_ready = tx_ready;
    assign if_r.tx_ready = tx_ready;

    tdc_trace_capture #(
        .NUM_CH(NCH), .DEPTH(DEP), .PRETRIG(PRE), .MARK_DONE(8'hFF), .MARK_EN(1'b1)
    ) u_dut_m (
        .clk(clk), .rstn(rstn), .sample_i(sample_i), .sample_vld_i(sample_vld_i), .arm_i(arm_i),
        .trig_i(trig_i), .done_i(done_i), .clear_i(clear_i), .dump_i(dump_i), .tx(if_m),
        .busy_o(busy_m), .full_o(full_m), .pre_short_o(short_m)
    );

    tdc_trace_capture #(
        .NUM_CH(NCH), .DEPTH(DEP), .PRETRIG(PRE), .MARK_DONE(8'hFF), .MARK_EN(1'b0)
    ) u_dut_r (
        .clk(clk), .rstn(rstn), .sample_i(sample_i), .sample_vld_i(sample_vld_i), .arm_i(arm_i),
        .trig_i(trig_i), .done_i(done_i), .clear_i(clear_i), .dump_i(dump_i), .tx(if_r),
        .busy_o(busy_r), .full_o(full_r), .pre_short_o(short_r)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] pre_hist[$];
    logic [15:0] win[$];
    bit          win_mark[$];
    logic [7:0]  exp_m[NB];
    logic [7:0]  exp_r[NB];
    int          pre_kept;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] gen(input int n, input bit rnd);
        logic [7:0] b;
        b = 8'(n);
        if (rnd) return 16'($urandom);
        return {8'h80 + b, b};
    endfunction

    // Dump = (PRE - kept) zero samples, then the recorded window in time order, truncated to DEP.
    task automatic build_expect();
        int z;
        int b;
        logic [15:0] w;
        z = int'(PRE) - pre_kept;
        for (int s = 0; s < int'(DEP); s++) begin
            for (int c = 0; c < int'(NCH); c++) begin
                b = s * int'(NCH) + c;
                if (s < z) begin
                    exp_m[b] = 8'h00;
                    exp_r[b] = 8'h00;
                end else begin
                    w = win[s - z];
                    exp_r[b] = w[c*8 +: 8];
                    exp_m[b] = win_mark[s - z] ? 8'hFF : w[c*8 +: 8];
                end
            end
        end
    endtask

    task automatic do_capture(input int npre, input bit trig_smp, input int done_at,
                              input bit rnd, input bit poke);
        int n, post, goal, budget;
        logic [15:0] smp;
        bit vld, dn;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("arm_busy", 32'(busy_m), 32'd1);
        check("arm_short_clr", 32'(short_m), 32'd0);
        pre_hist.delete();
        win.delete();
        win_mark.delete();
        n = 0;
        budget = 0;
        while (pre_hist.size() < npre && budget < 200) begin
            vld = rnd ? ($urandom_range(3) != 0) : 1'b1;
            smp = gen(n, rnd);
            sample_vld_i = vld;
            sample_i     = smp;
            done_i       = rnd ? 1'($urandom_range(1)) : 1'b0;
            dump_i       = poke && (budget == 0);
            tick();
            dump_i = 1'b0;
            if (poke && budget == 0) begin
                check("dump_in_armed_busy", 32'(busy_m), 32'd1);
                check("dump_in_armed_full", 32'(full_m), 32'd0);
            end
            if (vld) begin
                pre_hist.push_back(smp);
                n++;
            end
            budget++;
        end
        pre_kept = (pre_hist.size() < int'(PRE)) ? pre_hist.size() : int'(PRE);
        for (int i = pre_hist.size() - pre_kept; i < pre_hist.size(); i++) begin
            win.push_back(pre_hist[i]);
            win_mark.push_back(1'b0);
        end
        goal = int'(DEP) - pre_kept;
        smp = gen(n, rnd);
        dn  = (done_at == 0) || (done_at == -2 && $urandom_range(3) == 0);
        trig_i = 1'b1;
        sample_vld_i = trig_smp;
        sample_i = smp;
        done_i = dn;
        tick();
        trig_i = 1'b0;
        post = 0;
        if (trig_smp) begin
            win.push_back(smp);
            win_mark.push_back(dn);
            post = 1;
            n++;
        end
        check("trig_full", 32'(full_m), 32'(post == goal));
        budget = 0;
        while (post < goal && budget < 300) begin
            vld = rnd ? ($urandom_range(3) != 0) : 1'b1;
            smp = gen(n, rnd);
            dn  = (done_at == -2) ? ($urandom_range(7) == 0) : (vld && post == done_at);
            sample_vld_i = vld;
            sample_i = smp;
            done_i = dn;
            tick();
            if (vld) begin
                win.push_back(smp);
                win_mark.push_back(dn);
                post++;
                n++;
            end
            check("cap_full", 32'(full_m), 32'(post == goal));
            budget++;
        end
        sample_vld_i = 1'b0;
        done_i = 1'b0;
        check("full_m", 32'(full_m), 32'd1);
        check("full_r", 32'(full_r), 32'd1);
        check("pre_short_m", 32'(short_m), 32'(pre_kept < int'(PRE)));
        check("pre_short_r", 32'(short_r), 32'(pre_kept < int'(PRE)));
        // arm, trig and samples while FULL must neither change state nor touch the window
        arm_i = 1'b1;
        trig_i = 1'b1;
        sample_vld_i = 1'b1;
        sample_i = 16'hA55A;
        tick();
        arm_i = 1'b0;
        trig_i = 1'b0;
        sample_vld_i = 1'b0;
        check("full_hold", 32'(full_m), 32'd1);
        build_expect();
    endtask

    task automatic do_dump(input int mode, input int abort_after);
        int idx, cyc, first, limit;
        bit held;
        logic [7:0] hd;
        logic hl;
        limit = (abort_after >= 0) ? abort_after : int'(NB);
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        check("dump_busy", 32'(busy_m), 32'd1);
        check("dump_full_clr", 32'(full_m), 32'd0);
        idx = 0;
        cyc = 0;
        first = -1;
        held = 1'b0;
        hd = '0;
        hl = 1'b0;
        while (idx < limit && cyc < 400) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: tx_ready = 1'($urandom_range(1));
            endcase
            if (if_m.tx_valid && first < 0) first = cyc;
            if (held) begin
                check("stall_valid", 32'(if_m.tx_valid), 32'd1);
                check("stall_data", 32'(if_m.tx_data), 32'(hd));
                check("stall_last", 32'(if_m.tx_last), 32'(hl));
            end
            if (if_m.tx_valid && tx_ready) begin
                check("byte_m", 32'(if_m.tx_data), 32'(exp_m[idx]));
                check("byte_r", 32'(if_r.tx_data), 32'(exp_r[idx]));
                check("last_m", 32'(if_m.tx_last), 32'(idx == int'(NB) - 1));
                check("last_r", 32'(if_r.tx_last), 32'(idx == int'(NB) - 1));
                idx++;
            end
            held = if_m.tx_valid && !tx_ready;
            hd = if_m.tx_data;
            hl = if_m.tx_last;
            tick();
            cyc++;
        end
        check("dump_count", 32'(idx), 32'(limit));
        check("first_valid_lat", 32'(first >= 0 && first <= 3), 32'd1);
        if (abort_after < 0) begin
            check("idle_after", 32'(busy_m), 32'd0);
            check("valid_after", 32'(if_m.tx_valid), 32'd0);
            check("short_held", 32'(short_m), 32'(pre_kept < int'(PRE)));
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        sample_i = '0;
        sample_vld_i = 1'b0;
        arm_i = 1'b0;
        trig_i = 1'b0;
        done_i = 1'b0;
        clear_i = 1'b0;
        dump_i = 1'b0;
        tx_ready = 1'b1;
        pre_kept = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_full", 32'(full_m), 32'd0);
        check("rst_short", 32'(short_m), 32'd0);
        check("rst_valid", 32'(if_m.tx_valid), 32'd0);
        check("rst_last", 32'(if_m.tx_last), 32'd0);
        check("rst_data", 32'(if_m.tx_data), 32'd0);
        rstn = 1'b1;
        tick();

        // Counting pattern, full pre-trigger history, ready always high.
        do_capture(10, 1'b1, -1, 1'b0, 1'b0);
        do_dump(0, -1);
        // Short pre-trigger history, ready 1,0,0,1.
        do_capture(2, 1'b1, -1, 1'b0, 1'b0);
        do_dump(1, -1);
        // done on post sample 5; then done coinciding with trigger; then trigger with no sample.
        do_capture(6, 1'b1, 5, 1'b1, 1'b0);
        do_dump(2, -1);
        do_capture(4, 1'b1, 0, 1'b1, 1'b0);
        do_dump(0, -1);
        do_capture(3, 1'b0, -2, 1'b1, 1'b0);
        do_dump(1, -1);

        // Abort from CAPTURE via clear_i.
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        sample_vld_i = 1'b1;
        repeat (5) tick();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        repeat (3) tick();
        sample_vld_i = 1'b0;
        check("clr_pre_busy", 32'(busy_m), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_busy", 32'(busy_m), 32'd0);
        check("clr_full", 32'(full_m), 32'd0);
        dump_i = 1'b1;
        tick();
        dump_i = 1'b0;
        check("dump_in_idle", 32'(busy_m), 32'd0);

        // Async reset in the middle of a dump.
        do_capture(8, 1'b1, -2, 1'b1, 1'b0);
        do_dump(2, 7);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(if_m.tx_valid), 32'd0);
        check("mid_rst_last", 32'(if_m.tx_last), 32'd0);
        check("mid_rst_busy", 32'(busy_m), 32'd0);
        check("mid_rst_full", 32'(full_m), 32'd0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();

        // trig in IDLE ignored; dump_i while ARMED ignored.
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        check("trig_idle_busy", 32'(busy_m), 32'd0);
        check("trig_idle_full", 32'(full_m), 32'd0);
        do_capture(5, 1'b1, -1, 1'b1, 1'b1);
        do_dump(0, -1);

        for (int k = 0; k < 4; k++) begin
            do_capture(int'($urandom_range(24)), 1'($urandom_range(1)), -2, 1'b1, 1'b0);
            do_dump(int'($urandom_range(2)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
